axil_rd_timeout: RTL and testbench

- AXI-lite read watchdog in the s_clk domain, placed directly upstream of the AXI-lite read clock-domain crossing.
- Forwards one read at a time to the crossing.
- If no R beat returns within TIMEOUT cycles, it answers upstream itself with SLVERR and ERR_DATA, then silently drains the late response.
- Purpose: keeps the host bus live when the far clock domain is stopped or held in reset.

---
 rtl/axil_pkg.sv | 16 +
 rtl/axil_rd_timeout.sv | 184 ++++++++++++++++++
 tb/tb_axil_rd_timeout.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-lite definitions: response codes and the read-watchdog state encoding.
`timescale 1ns/1ps
package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WAIT_R = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } rd_state_e;

endpackage

// File: rtl/axil_rd_timeout.sv
// AXI-lite read watchdog ahead of the read CDC: forwards one read at a time and
// answers with SLVERR/ERR_DATA if the far side stays silent, draining the late beat.
`timescale 1ns/1ps
module axil_rd_timeout
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  s_clk,
  input  logic                  s_rst,

  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,

  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,

  output logic                  timeout_pulse,
  output logic [CNT_WIDTH-1:0]  timeout_count,
  output logic                  busy
);

  // Watchdog only needs to reach TIMEOUT-1; it wraps harmlessly when disabled.
  localparam int unsigned WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0]     WDOG_LAST = WDOG_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_D     = DATA_WIDTH'(ERR_DATA);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;
  logic                  m_arvalid_q, m_arvalid_d;
  logic                  ar_done_q, ar_done_d;
  logic                  drain_pend_q, drain_pend_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  s_rvalid_q, s_rvalid_d;
  logic                  pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic ar_hs;
  logic r_hs;
  logic fire;

  assign s_axil_arready = (state_q == IDLE);
  assign m_axil_rready  = (state_q == WAIT_R) || ((state_q == DRAIN) && ar_done_q);

  assign ar_hs = m_arvalid_q && m_axil_arready;
  assign r_hs  = m_axil_rvalid && m_axil_rready;
  assign fire  = (TIMEOUT != 0) && ((state_q == ADDR) || (state_q == WAIT_R)) &&
                 !r_hs && (wdog_q == WDOG_LAST);

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arprot_d     = arprot_q;
    m_arvalid_d  = m_arvalid_q;
    ar_done_d    = ar_done_q;
    drain_pend_d = drain_pend_q;
    wdog_d       = wdog_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    s_rvalid_d   = s_rvalid_q;
    pulse_d      = 1'b0;
    count_d      = count_q;

    // AR may complete in ADDR, RESP or DRAIN; the handshake is tracked independently of state.
    if (ar_hs) begin
      m_arvalid_d = 1'b0;
      ar_done_d   = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (s_axil_arvalid) begin
          araddr_d    = s_axil_araddr;
          arprot_d    = s_axil_arprot;
          m_arvalid_d = 1'b1;
          wdog_d      = '0;
          ar_done_d   = 1'b0;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        wdog_d = wdog_q + 1'b1;
        if (!fire && ar_hs) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (r_hs) begin
          rdata_d    = m_axil_rdata;
          rresp_d    = m_axil_rresp;
          s_rvalid_d = 1'b1;
          state_d    = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP: begin
        if (s_axil_rready) begin
          s_rvalid_d = 1'b0;
          state_d    = drain_pend_q ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (r_hs) begin
          drain_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire) begin
      rdata_d      = ERR_D;
      rresp_d      = AXIL_RESP_SLVERR;
      s_rvalid_d   = 1'b1;
      drain_pend_d = 1'b1;
      pulse_d      = 1'b1;
      if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end
      state_d = RESP;
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q      <= IDLE;
      araddr_q     <= '0;
      arprot_q     <= '0;
      m_arvalid_q  <= 1'b0;
      ar_done_q    <= 1'b0;
      drain_pend_q <= 1'b0;
      wdog_q       <= '0;
      rdata_q      <= '0;
      rresp_q      <= '0;
      s_rvalid_q   <= 1'b0;
      pulse_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arprot_q     <= arprot_d;
      m_arvalid_q  <= m_arvalid_d;
      ar_done_q    <= ar_done_d;
      drain_pend_q <= drain_pend_d;
      wdog_q       <= wdog_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      s_rvalid_q   <= s_rvalid_d;
      pulse_q      <= pulse_d;
      count_q      <= count_d;
    end
  end

  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = arprot_q;
  assign m_axil_arvalid = m_arvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rvalid  = s_rvalid_q;
  assign timeout_pulse  = pulse_q;
  assign timeout_count  = count_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_axil_rd_timeout.sv
// Scoreboard bench for axil_rd_timeout: normal reads, timeouts, late-beat drain and reset.
`timescale 1ns/1ps
module tb_axil_rd_timeout;

  logic        s_clk = 1'b0;
  logic        s_rst = 1'b1;

  logic [31:0] s_axil_araddr = '0;
  logic [2:0]  s_axil_arprot = '0;
  logic        s_axil_arvalid = 1'b0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1'b1;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready = 1'b1;
  logic [31:0] m_axil_rdata = '0;
  logic [1:0]  m_axil_rresp = '0;
  logic        m_axil_rvalid = 1'b0;
  logic        m_axil_rready;
  logic        timeout_pulse;
  logic [15:0] timeout_count;
  logic        busy;

  // Second instance with the watchdog disabled.
  logic        z_arvalid = 1'b0;
  logic        z_arready;
  logic [31:0] z_rdata;
  logic [1:0]  z_rresp;
  logic        z_rvalid;
  logic [31:0] z_m_araddr;
  logic [2:0]  z_m_arprot;
  logic        z_m_arvalid;
  logic        z_m_rready;
  logic        z_pulse;
  logic [15:0] z_count;
  logic        z_busy;

  int n_chk = 0;
  int n_err = 0;
  logic [33:0] sb_q[$];
  logic        pulse_prev = 1'b0;
  int          pulse_cycles = 0;

  always #5 s_clk = ~s_clk;

  axil_rd_timeout #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16),
                    .ERR_DATA(32'hDEADBEEF), .CNT_WIDTH(16)) u_dut (
    .s_clk(s_clk), .s_rst(s_rst),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .timeout_pulse(timeout_pulse), .timeout_count(timeout_count), .busy(busy)
  );

  axil_rd_timeout #(.TIMEOUT(0)) u_dut_nowd (
    .s_clk(s_clk), .s_rst(s_rst),
    .s_axil_araddr(32'h0000_0500), .s_axil_arprot(3'd0),
    .s_axil_arvalid(z_arvalid), .s_axil_arready(z_arready),
    .s_axil_rdata(z_rdata), .s_axil_rresp(z_rresp),
    .s_axil_rvalid(z_rvalid), .s_axil_rready(1'b1),
    .m_axil_araddr(z_m_araddr), .m_axil_arprot(z_m_arprot),
    .m_axil_arvalid(z_m_arvalid), .m_axil_arready(1'b1),
    .m_axil_rdata(32'h0), .m_axil_rresp(2'b00),
    .m_axil_rvalid(1'b0), .m_axil_rready(z_m_rready),
    .timeout_pulse(z_pulse), .timeout_count(z_count), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  // Presents one AR upstream; returns in the first cycle m_axil_arvalid is high.
  task automatic issue(input logic [31:0] addr, input logic [2:0] prot);
    int n;
    s_axil_araddr  = addr;
    s_axil_arprot  = prot;
    s_axil_arvalid = 1'b1;
    n = 0;
    while (!s_axil_arready && n < 50) begin
      tick();
      n++;
    end
    check("ar_accept_wait", 64'(n < 50), 64'd1);
    tick();
    s_axil_arvalid = 1'b0;
  endtask

  task automatic wait_rvalid(output int cyc);
    cyc = 0;
    while (!s_axil_rvalid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  // Upstream R monitor: every accepted beat must match the scoreboard head.
  always @(negedge s_clk) begin
    if (pulse_prev) check("pulse_single", 64'(timeout_pulse), 64'd0);
    pulse_prev <= timeout_pulse;
    if (timeout_pulse) pulse_cycles <= pulse_cycles + 1;
    if (!s_rst && s_axil_rvalid && s_axil_rready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 64'(s_axil_rvalid), 64'd0);
      end else begin
        logic [33:0] e;
        e = sb_q.pop_front();
        check("sb_rdata", 64'(s_axil_rdata), 64'(e[33:2]));
        check("sb_rresp", 64'(s_axil_rresp), 64'(e[1:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cyc;
    int p0;
    logic z_seen;

    repeat (3) tick();
    check("rst_arvalid", 64'(m_axil_arvalid), 64'd0);
    check("rst_rvalid", 64'(s_axil_rvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(timeout_count), 64'd0);
    s_rst = 1'b0;
    tick();
    check("idle_arready", 64'(s_axil_arready), 64'd1);

    // Normal read, downstream responds at once.
    p0 = pulse_cycles;
    m_axil_arready = 1'b1;
    issue(32'h0000_0100, 3'd5);
    check("t1_m_arvalid", 64'(m_axil_arvalid), 64'd1);
    check("t1_m_araddr", 64'(m_axil_araddr), 64'h100);
    check("t1_m_arprot", 64'(m_axil_arprot), 64'd5);
    tick();
    check("t1_m_rready", 64'(m_axil_rready), 64'd1);
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'h1234_5678;
    m_axil_rresp  = 2'b00;
    sb_q.push_back({32'h1234_5678, 2'b00});
    tick();
    m_axil_rvalid = 1'b0;
    check("t1_latency", 64'(s_axil_rvalid), 64'd1);
    tick();
    check("t1_idle", 64'(busy), 64'd0);
    check("t1_no_pulse", 64'(pulse_cycles - p0), 64'd0);

    // Silent far side: synthesized SLVERR after exactly 16 cycles, then drain.
    p0 = pulse_cycles;
    sb_q.push_back({32'hDEAD_BEEF, 2'b10});
    issue(32'h0000_0200, 3'd0);
    wait_rvalid(cyc);
    check("t2_to_cycles", 64'(cyc), 64'd16);
    check("t2_pulse", 64'(timeout_pulse), 64'd1);
    check("t2_count", 64'(timeout_count), 64'd1);
    tick();
    check("t2_drain_busy", 64'(busy), 64'd1);
    check("t2_drain_rvalid", 64'(s_axil_rvalid), 64'd0);
    check("t2_drain_arready", 64'(s_axil_arready), 64'd0);
    repeat (20) tick();
    check("t2_still_busy", 64'(busy), 64'd1);
    check("t2_drain_rready", 64'(m_axil_rready), 64'd1);
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'hAAAA_5555;
    tick();
    m_axil_rvalid = 1'b0;
    check("t2_back_idle", 64'(s_axil_arready), 64'd1);
    check("t2_no_rvalid", 64'(s_axil_rvalid), 64'd0);
    check("t2_pulse_cycles", 64'(pulse_cycles - p0), 64'd1);

    // AR stalled for 30 cycles: error at 16, AR held stable, then drained.
    m_axil_arready = 1'b0;
    s_axil_rready  = 1'b0;
    sb_q.push_back({32'hDEAD_BEEF, 2'b10});
    issue(32'h0000_0300, 3'd2);
    wait_rvalid(cyc);
    check("t3_to_cycles", 64'(cyc), 64'd16);
    check("t3_count", 64'(timeout_count), 64'd2);
    check("t3_m_arvalid", 64'(m_axil_arvalid), 64'd1);
    check("t3_resp_rready", 64'(m_axil_rready), 64'd0);
    repeat (3) tick();
    check("t3_hold_rvalid", 64'(s_axil_rvalid), 64'd1);
    check("t3_hold_rdata", 64'(s_axil_rdata), 64'hDEAD_BEEF);
    s_axil_rready = 1'b1;
    tick();
    check("t3_drain_busy", 64'(busy), 64'd1);
    check("t3_drain_rready", 64'(m_axil_rready), 64'd0);
    repeat (10) tick();
    check("t3_addr_stable", 64'(m_axil_araddr), 64'h300);
    check("t3_arvalid_held", 64'(m_axil_arvalid), 64'd1);
    m_axil_arready = 1'b1;
    tick();
    check("t3_ar_accepted", 64'(m_axil_arvalid), 64'd0);
    check("t3_rready_after_ar", 64'(m_axil_rready), 64'd1);
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'h0000_0077;
    tick();
    m_axil_rvalid = 1'b0;
    check("t3_idle", 64'(busy), 64'd0);

    // R handshake on the expiry edge: real data wins.
    p0 = pulse_cycles;
    issue(32'h0000_0400, 3'd0);
    repeat (15) tick();
    check("t4_not_yet", 64'(s_axil_rvalid), 64'd0);
    m_axil_rvalid = 1'b1;
    m_axil_rdata  = 32'h5A5A_1234;
    m_axil_rresp  = 2'b00;
    sb_q.push_back({32'h5A5A_1234, 2'b00});
    tick();
    m_axil_rvalid = 1'b0;
    check("t4_rvalid", 64'(s_axil_rvalid), 64'd1);
    check("t4_count", 64'(timeout_count), 64'd2);
    tick();
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_no_pulse", 64'(pulse_cycles - p0), 64'd0);

    // Reset while waiting for R.
    issue(32'h0000_0600, 3'd0);
    tick();
    check("t5_wait_rready", 64'(m_axil_rready), 64'd1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    check("t5a_arvalid", 64'(m_axil_arvalid), 64'd0);
    check("t5a_rvalid", 64'(s_axil_rvalid), 64'd0);
    check("t5a_rready", 64'(m_axil_rready), 64'd0);
    check("t5a_busy", 64'(busy), 64'd0);
    check("t5a_count", 64'(timeout_count), 64'd0);

    // Reset while draining.
    sb_q.push_back({32'hDEAD_BEEF, 2'b10});
    issue(32'h0000_0700, 3'd0);
    wait_rvalid(cyc);
    check("t5b_to_cycles", 64'(cyc), 64'd16);
    tick();
    check("t5b_drain_busy", 64'(busy), 64'd1);
    check("t5b_count_pre", 64'(timeout_count), 64'd1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    check("t5b_rready", 64'(m_axil_rready), 64'd0);
    check("t5b_busy", 64'(busy), 64'd0);
    check("t5b_count", 64'(timeout_count), 64'd0);
    check("t5b_arvalid", 64'(m_axil_arvalid), 64'd0);

    // TIMEOUT=0: no response ever, no timeout ever.
    z_arvalid = 1'b1;
    tick();
    z_arvalid = 1'b0;
    z_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (z_rvalid || z_pulse) z_seen = 1'b1;
    end
    check("t6_no_response", 64'(z_seen), 64'd0);
    check("t6_busy", 64'(z_busy), 64'd1);
    check("t6_count", 64'(z_count), 64'd0);
    check("t6_rready", 64'(z_m_rready), 64'd1);

    tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
